// File: rtl/addsub_pipe.sv
// Pipelined add/subtract with wrap or saturating modes, carry/borrow and signed
// overflow flags, a stall-together pipeline and a saturating overflow counter.
module addsub_pipe #(
  parameter int N      = 32,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         carry,
  output logic         ovf,
  input  logic         cnt_clr,
  output logic [15:0]  ovf_cnt
);

  // Handshake: a transfer happens on a cycle where valid && ready are both high.
  // Every stage moves together when the output is free (adv); bubbles travel
  // through and are not collapsed, so in_ready is simply adv.
  logic adv;
  logic accept;

  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  localparam logic [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

  logic [N:0]   raw;
  logic         is_sub;
  logic         res_ovf;
  logic         res_carry;
  logic [N-1:0] res_sum;

  // Zero-extended operands make raw[N] the unsigned carry (add) or borrow (sub).
  always_comb begin
    is_sub = mode[0];
    if (is_sub) raw = {1'b0, a} - {1'b0, b};
    else        raw = {1'b0, a} + {1'b0, b};
    res_carry = raw[N];
    if (is_sub) res_ovf = (a[N-1] != b[N-1]) && (raw[N-1] != a[N-1]);
    else        res_ovf = (a[N-1] == b[N-1]) && (raw[N-1] != a[N-1]);
    res_sum = raw[N-1:0];
    // On overflow the true result carries the sign of a in both add and sub.
    if (mode[1] && res_ovf) res_sum = a[N-1] ? SMIN : SMAX;
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] o_q;
  logic [N-1:0]      s_q [STAGES];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      v_q <= '0;
      c_q <= '0;
      o_q <= '0;
      for (int i = 0; i < STAGES; i++) s_q[i] <= '0;
    end else if (adv) begin
      v_q[0] <= accept;
      if (accept) begin
        s_q[0] <= res_sum;
        c_q[0] <= res_carry;
        o_q[0] <= res_ovf;
      end
      for (int i = 1; i < STAGES; i++) begin
        v_q[i] <= v_q[i-1];
        s_q[i] <= s_q[i-1];
        c_q[i] <= c_q[i-1];
        o_q[i] <= o_q[i-1];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign carry     = c_q[STAGES-1];
  assign ovf       = o_q[STAGES-1];

  // Counts delivered results only; clear wins over a same-cycle increment.
  logic deliver_ovf;
  assign deliver_ovf = out_valid && out_ready && ovf;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)                                   ovf_cnt <= '0;
    else if (cnt_clr)                            ovf_cnt <= '0;
    else if (deliver_ovf && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed cases, stall/reset scenarios,
// counter saturation and a randomized run against an arithmetic reference model.
module tb_addsub_pipe;
  localparam int N      = 32;
  localparam int STAGES = 2;

  logic         clk;
  logic         rstN;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         carry;
  logic         ovf;
  logic         cnt_clr;
  logic [15:0]  ovf_cnt;

  addsub_pipe #(.N(N), .STAGES(STAGES)) dut (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .ovf(ovf), .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Packed expectation: {carry, ovf, sum}
  function automatic logic [N+1:0] ref_op(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic [1:0] m);
    longint sx, sy, tr, smax, smin, ux, uy;
    logic ov, cy;
    logic [63:0] t64;
    logic [N-1:0] s;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    ux   = longint'(x);
    uy   = longint'(y);
    smax = (longint'(1) <<< (N-1)) - 1;
    smin = -(longint'(1) <<< (N-1));
    tr   = m[0] ? (sx - sy) : (sx + sy);
    ov   = (tr > smax) || (tr < smin);
    cy   = m[0] ? (ux < uy) : ((ux + uy) > ((longint'(1) <<< N) - 1));
    if (m[1] && ov) t64 = (tr > 0) ? 64'(smax) : 64'(smin);
    else            t64 = 64'(tr);
    s = t64[N-1:0];
    return {cy, ov, s};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [N+1:0] exp_q[$];
  logic [15:0]  model_cnt = 16'd0;
  int           delivered = 0;
  logic         prev_stall = 1'b0;
  logic [N+2:0] saved_out;

  always @(negedge clk) begin
    if (!rstN) begin
      exp_q.delete();
      model_cnt  = 16'd0;
      prev_stall = 1'b0;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_ovf_cnt", 64'(ovf_cnt), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
    end else begin
      logic [N+1:0] e;
      logic d_ovf;
      d_ovf = 1'b0;
      check("ovf_cnt", 64'(ovf_cnt), 64'(model_cnt));
      check("in_ready", 64'(in_ready), 64'(out_ready || !out_valid));
      if (prev_stall) begin
        check("stall_hold", 64'({out_valid, carry, ovf, sum}), 64'(saved_out));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_delivery", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          delivered++;
          check("sum", 64'(sum), 64'(e[N-1:0]));
          check("ovf", 64'(ovf), 64'(e[N]));
          check("carry", 64'(carry), 64'(e[N+1]));
          d_ovf = e[N];
        end
      end
      if (cnt_clr) model_cnt = 16'd0;
      else if (d_ovf && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
      prev_stall = out_valid && !out_ready;
      saved_out  = {out_valid, carry, ovf, sum};
      if (in_valid && in_ready) exp_q.push_back(ref_op(a, b, mode));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic [1:0] m);
    logic taken;
    int budget;
    a = x; b = y; mode = m; in_valid = 1'b1;
    taken  = 1'b0;
    budget = 0;
    while (!taken && budget < 200) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk); #1;
      budget++;
    end
    if (!taken) check("send_timeout", 64'(taken), 64'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; mode = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Pipeline must be empty and out_ready high; checks latency and constant results.
  task automatic direct(input logic [N-1:0] x, input logic [N-1:0] y, input logic [1:0] m,
                        input logic [N-1:0] es, input logic ec, input logic eo);
    send(x, y, m);
    idle();
    for (int k = 1; k < STAGES; k++) begin
      check("latency_early", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    check("latency_valid", 64'(out_valid), 64'd1);
    check("direct_sum", 64'(sum), 64'(es));
    check("direct_carry", 64'(carry), 64'(ec));
    check("direct_ovf", 64'(ovf), 64'(eo));
    @(posedge clk); #1;
  endtask

  function automatic logic [N-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return {1'b0, {(N-1){1'b1}}};
      1:       return {1'b1, {(N-1){1'b0}}};
      2:       return '0;
      3:       return '1;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    rstN = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 2'b00;
    out_ready = 1'b1; cnt_clr = 1'b0;
    #2;
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_carry", 64'(carry), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;

    // Directed arithmetic cases with latency checks
    direct(32'd15, 32'd7, 2'b00, 32'd22, 1'b0, 1'b0);
    direct(32'd10, 32'd20, 2'b01, 32'hFFFFFFF6, 1'b1, 1'b0);
    direct(32'h7FFFFFFF, 32'd1, 2'b00, 32'h80000000, 1'b0, 1'b1);
    direct(32'h7FFFFFFF, 32'd1, 2'b10, 32'h7FFFFFFF, 1'b0, 1'b1);
    direct(32'h80000000, 32'd1, 2'b11, 32'h80000000, 1'b0, 1'b1);
    direct(32'hFFFFFFFF, 32'd1, 2'b00, 32'h00000000, 1'b1, 1'b0);
    direct(32'h80000000, 32'h80000000, 2'b10, 32'h80000000, 1'b1, 1'b1);
    check("cnt_after_direct", 64'(ovf_cnt), 64'd4);

    // Back-to-back stream of 4 with a 3-cycle output stall
    delivered = 0;
    out_ready = 1'b0;
    send(32'd1, 32'd2, 2'b00);
    send(32'd100, 32'd3, 2'b01);
    fork
      begin
        send(32'h7FFFFFFF, 32'h7FFFFFFF, 2'b10);
        send(32'h80000000, 32'h7FFFFFFF, 2'b11);
        idle();
      end
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", 64'(delivered), 64'd4);

    // Reset with two operations in flight
    out_ready = 1'b0;
    send(32'd5, 32'd6, 2'b00);
    send(32'd7, 32'd8, 2'b00);
    idle();
    check("inflight_valid", 64'(out_valid), 64'd1);
    rstN = 1'b0;
    #1 check("reset_immediate", 64'(out_valid), 64'd0);
    @(posedge clk); #1 rstN = 1'b1;
    out_ready = 1'b1;
    delivered = 0;
    direct(32'd3, 32'd4, 2'b00, 32'd7, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 check("post_reset_deliveries", 64'(delivered), 64'd1);

    // Drive ovf_cnt to saturation with a continuous overflow stream
    a = 32'h7FFFFFFF; b = 32'd1; mode = 2'b00; in_valid = 1'b1;
    repeat (65545) @(posedge clk);
    #1 check("cnt_saturated", 64'(ovf_cnt), 64'hFFFF);
    cnt_clr = 1'b1;
    check("clr_coincident_ovf", 64'(out_valid && ovf), 64'd1);
    @(posedge clk); #1 cnt_clr = 1'b0;
    check("cnt_clr_priority", 64'(ovf_cnt), 64'd0);
    idle();
    drain();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) < 7) begin
        in_valid = 1'b1;
        a = rand_operand(); b = rand_operand(); mode = 2'($urandom_range(0, 3));
      end else begin
        idle();
      end
      @(posedge clk); #1;
    end
    idle();
    cnt_clr   = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 Parameter N, default 32: operand and result width, legal range 8..64.
REQ-002 Parameter STAGES, default 2: pipeline depth, legal range 1..4.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 Port rstN, input, 1: asynchronous active-low reset.
REQ-005 Port in_valid, input, 1: operand set a/b/mode is presented.
REQ-006 Port in_ready, output, 1: block accepts the operand set this cycle.
REQ-007 Port a, input, N: operand A, two's complement.
REQ-008 Port b, input, N: operand B, two's complement.
REQ-009 Port mode, input, 2: 00 wrap add, 01 wrap sub, 10 saturating add, 11 saturating sub.
REQ-010 Port out_valid, output, 1: result on sum/carry/ovf is valid.
REQ-011 Port out_ready, input, 1: downstream consumes the result this cycle.
REQ-012 Port sum, output, N: result.
REQ-013 Port carry, output, 1: add gives unsigned carry-out; sub gives unsigned borrow (a < b unsigned).
REQ-014 Port ovf, output, 1: signed overflow of the unsaturated operation.
REQ-015 Port cnt_clr, input, 1: synchronous clear of ovf_cnt.
REQ-016 Port ovf_cnt, output, 16: count of delivered results with ovf=1.

Function
REQ-017 Accept on in_valid && in_ready; deliver on out_valid && out_ready.
REQ-018 Stall pipeline: all stages advance together when adv = out_ready || !out_valid; in_ready = adv; bubbles are not collapsed.
REQ-019 Stage 1 computes the result and flags from the accepted inputs; stages 2..STAGES delay it unchanged; the valid bit travels with the data.
REQ-020 Latency: a result accepted in cycle t with no stall shows out_valid in cycle t+STAGES; throughput is one result per cycle.
REQ-021 While stalled (!adv): every stage register, out_valid, sum, carry and ovf hold stable.
REQ-022 Arithmetic uses an N+1-bit internal width; sum is the low N bits for modes 00 and 01.
REQ-023 ovf=1 when the operands' signs satisfy the overflow rule for the operation and the result sign differs (add: signs equal; sub: signs differ).
REQ-024 Modes 10 and 11 with ovf=1 clamp sum to 2^(N-1)-1 if the true result is positive and to -2^(N-1) if negative; ovf still reports 1.
REQ-025 carry and ovf are computed from the unsaturated operation in all modes.
REQ-026 When a delivery has ovf=1, ovf_cnt increments by 1; it saturates at 0xFFFF.
REQ-027 cnt_clr=1 sets ovf_cnt to 0 next cycle; clear takes priority over a simultaneous increment.
REQ-028 Inputs presented with in_valid=0 or in_ready=0 are ignored; values on a/b/mode outside acceptance have no effect.

Reset
REQ-029 rstN low immediately clears all stage valid bits, out_valid, sum, carry, ovf and ovf_cnt to 0.
REQ-030 During reset in_ready=1; in-flight operations are discarded and never delivered.
REQ-031 The first acceptance is possible on the first posedge with rstN high.

Verification
REQ-032 N=32, STAGES=2, out_ready=1: accept a=15, b=7, mode=00 at cycle t -> cycle t+2: out_valid=1, sum=22, carry=0, ovf=0.
REQ-033 a=10, b=20, mode=01 -> sum=0xFFFFFFF6, carry=1, ovf=0; a=0x7FFFFFFF, b=1: mode=00 -> sum=0x80000000, ovf=1; mode=10 -> sum=0x7FFFFFFF, ovf=1.
REQ-034 a=0x80000000, b=1, mode=11 -> sum=0x80000000, ovf=1, carry=0; ovf_cnt increments once per delivery, not per acceptance.
REQ-035 Back-to-back stream of 4 operations with out_ready held low for 3 cycles -> in_ready=0 during the stall, outputs stable, all 4 results delivered in order with none lost or duplicated.
REQ-036 Force ovf_cnt to 0xFFFF through ovf deliveries -> further ovf deliveries leave it at 0xFFFF; cnt_clr coincident with an ovf delivery -> 0.
REQ-037 Assert rstN low with 2 operations in flight -> out_valid=0 immediately, neither result is ever delivered, and a new operation after reset returns its result after STAGES cycles.
